// File: rtl/reaction_ctrl.sv
// Reaction-timer game controller: random stimulus delay, BCD counter
// enable/clear generation, stimulus and cheat LED drive.
module reaction_ctrl #(
  parameter int unsigned LFSR_W    = 10,
  parameter int unsigned MIN_DELAY = 1000,
  parameter int unsigned DLY_W     = 12
) (
  input  logic              clk,
  input  logic              ar,
  input  logic              tick,
  input  logic              start_btn,
  input  logic              react_btn,
  input  logic [LFSR_W-1:0] lfsr,
  input  logic              ctr_full,
  output logic              ctr_en,
  output logic              ctr_clr_n,
  output logic              stim_led,
  output logic              cheat_led,
  output logic              timeout,
  output logic              busy,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_TIMING = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_CHEAT  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DLY_W-1:0] delay_cnt_q, delay_cnt_d;
  logic             timeout_q, timeout_d;
  logic             ctr_clr_n_q, ctr_clr_n_d;
  logic             start_q, react_q;
  logic             start_rise, react_rise;
  logic             ctr_en_d;

  assign start_rise = start_btn & ~start_q;
  assign react_rise = react_btn & ~react_q;

  // State, delay counter, timeout flag and clear pulse registers
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state_q     <= S_IDLE;
      delay_cnt_q <= '0;
      timeout_q   <= 1'b0;
      ctr_clr_n_q <= 1'b0;
      start_q     <= 1'b0;
      react_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_cnt_q <= delay_cnt_d;
      timeout_q   <= timeout_d;
      ctr_clr_n_q <= ctr_clr_n_d;
      start_q     <= start_btn;
      react_q     <= react_btn;
    end
  end

  // Next-state, delay reload/countdown and counter enable
  always_comb begin
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    timeout_d   = timeout_q;
    ctr_clr_n_d = 1'b1;
    ctr_en_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_CHEAT: begin
        // A new run may start from any resting state
        if (start_rise) begin
          state_d     = S_WAIT;
          delay_cnt_d = DLY_W'(MIN_DELAY) + DLY_W'(lfsr);
          timeout_d   = 1'b0;
          ctr_clr_n_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (react_rise) begin
          state_d = S_CHEAT;
        end else if (tick && (delay_cnt_q <= DLY_W'(1))) begin
          state_d = S_TIMING;
        end else if (tick) begin
          delay_cnt_d = delay_cnt_q - DLY_W'(1);
        end
      end
      S_TIMING: begin
        // A tick landing on the press cycle is not counted
        ctr_en_d = tick & ~react_rise & ~ctr_full;
        if (react_rise) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (ctr_full) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore decodes of the state register
  always_comb begin
    stim_led  = (state_q == S_TIMING);
    cheat_led = (state_q == S_CHEAT);
    busy      = (state_q == S_WAIT) || (state_q == S_TIMING);
    state     = state_q;
    timeout   = timeout_q;
    ctr_clr_n = ctr_clr_n_q;
    ctr_en    = ctr_en_d;
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: expected state snapshots are queued by
// the stimulus and popped by a monitor on every observed state change.
module tb_reaction_ctrl;

  logic       clk = 1'b0;
  logic       ar;
  logic       tick;
  logic       start_btn;
  logic       react_btn;
  logic [9:0] lfsr;
  logic       ctr_full;
  logic       ctr_en;
  logic       ctr_clr_n;
  logic       stim_led;
  logic       cheat_led;
  logic       timeout;
  logic       busy;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       stim;
    logic       cheat;
    logic       to;
    logic       bsy;
  } snap_t;

  snap_t      exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         en_cnt = 0;
  int         clr_cnt = 0;
  logic       mon_on = 1'b0;
  logic [2:0] prev_state = 3'd0;

  reaction_ctrl #(.LFSR_W(10), .MIN_DELAY(4), .DLY_W(12)) dut (
    .clk       (clk),
    .ar        (ar),
    .tick      (tick),
    .start_btn (start_btn),
    .react_btn (react_btn),
    .lfsr      (lfsr),
    .ctr_full  (ctr_full),
    .ctr_en    (ctr_en),
    .ctr_clr_n (ctr_clr_n),
    .stim_led  (stim_led),
    .cheat_led (cheat_led),
    .timeout   (timeout),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input logic [2:0] st, input logic stim, input logic cheat,
                              input logic to, input logic bsy);
    snap_t s;
    s = '{st: st, stim: stim, cheat: cheat, to: to, bsy: bsy};
    exp_q.push_back(s);
  endtask

  // One tick strobe followed by three quiet clocks
  task automatic do_tick(input int n);
    repeat (n) begin
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      step(3);
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
    step(1);
  endtask

  task automatic press_react();
    react_btn = 1'b1;
    step(1);
    react_btn = 1'b0;
    step(1);
  endtask

  // Monitor: counts enable/clear activity and checks every state change
  task automatic monitor();
    snap_t act;
    snap_t e;
    forever begin
      @(negedge clk);
      if (ar) begin
        if (ctr_en) en_cnt++;
        if (!ctr_clr_n) clr_cnt++;
      end
      if (mon_on && (state != prev_state)) begin
        act = '{st: state, stim: stim_led, cheat: cheat_led, to: timeout, bsy: busy};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got state=%0d snapshot=%b, required no change",
                   state, act);
        end else begin
          e = exp_q.pop_front();
          if (act != e) begin
            errors++;
            $display("FAIL snapshot: got %b (st/stim/cheat/to/busy), required %b", act, e);
          end
        end
      end
      prev_state = state;
    end
  endtask

  initial begin
    int en_snap;
    fork
      monitor();
    join_none

    ar = 1'b1; tick = 1'b0; start_btn = 1'b0; react_btn = 1'b0;
    lfsr = 10'd3; ctr_full = 1'b0;
    #1 ar = 1'b0;
    step(3);
    chk("rst_state", int'(state), 0);
    chk("rst_clr_n", int'(ctr_clr_n), 0);
    chk("rst_leds", int'({stim_led, cheat_led}), 0);
    chk("rst_busy_to", int'({busy, timeout}), 0);
    chk("rst_ctr_en", int'(ctr_en), 0);
    ar = 1'b1;
    #1;
    chk("clr_before_first_clk", int'(ctr_clr_n), 0);
    step(1);
    chk("clr_after_first_clk", int'(ctr_clr_n), 1);
    step(4);
    chk("idle_no_en", en_cnt, 0);
    chk("idle_state", int'(state), 0);
    clr_cnt = 0;
    prev_state = state;
    mon_on = 1'b1;

    // Normal run: D = 4 + 3 = 7 ticks
    expect_state(3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    press_start();
    chk("start_clr_pulse", clr_cnt, 1);
    chk("wait_state", int'(state), 1);
    do_tick(6);
    chk("wait_after_6_ticks", int'(state), 1);
    chk("wait_no_en", en_cnt, 0);
    expect_state(3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    do_tick(1);
    chk("timing_on_7th_tick", int'(stim_led), 1);
    do_tick(25);
    chk("en_25_ticks", en_cnt, 25);
    expect_state(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    press_react();
    chk("done_state", int'(state), 3);
    do_tick(2);
    chk("done_no_en", en_cnt, 25);
    press_react();
    chk("second_react_ignored", int'(state), 3);

    // Early press in WAIT at tick 2 of 7
    expect_state(3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    press_start();
    chk("restart_clr_pulse", clr_cnt, 2);
    do_tick(2);
    expect_state(3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    press_react();
    chk("cheat_led", int'(cheat_led), 1);
    do_tick(3);
    chk("cheat_no_en", en_cnt, 25);
    expect_state(3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    press_start();
    chk("cheat_restart_clr", clr_cnt, 3);
    chk("cheat_led_off", int'(cheat_led), 0);

    // Counter saturation ends the run with timeout
    expect_state(3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    do_tick(7);
    do_tick(3);
    chk("en_before_full", en_cnt, 28);
    expect_state(3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    ctr_full = 1'b1;
    tick = 1'b1;
    #1;
    chk("full_blocks_en", int'(ctr_en), 0);
    step(1);
    tick = 1'b0;
    ctr_full = 1'b0;
    step(3);
    chk("timeout_set", int'(timeout), 1);
    chk("full_no_count", en_cnt, 28);
    expect_state(3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    press_start();
    chk("timeout_cleared", int'(timeout), 0);

    // Press coincident with a tick is not counted
    expect_state(3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    do_tick(7);
    en_snap = en_cnt;
    expect_state(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick = 1'b1;
    react_btn = 1'b1;
    #1;
    chk("coincident_en", int'(ctr_en), 0);
    step(1);
    tick = 1'b0;
    react_btn = 1'b0;
    step(2);
    chk("coincident_done", int'(state), 3);
    chk("coincident_no_count", en_cnt, en_snap);

    // Asynchronous reset in the middle of TIMING
    expect_state(3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    press_start();
    expect_state(3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    do_tick(7);
    expect_state(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick = 1'b1;
    ar = 1'b0;
    #1;
    chk("midrun_rst_state", int'(state), 0);
    chk("midrun_rst_stim", int'(stim_led), 0);
    chk("midrun_rst_clr", int'(ctr_clr_n), 0);
    chk("midrun_rst_en", int'(ctr_en), 0);
    step(2);
    tick = 1'b0;
    ar = 1'b1;
    step(2);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
